// File: rtl/ctrl_mem_write_banked.sv
// Banked memory write controller: zero-latency writes from a valid/ready stream into NUM_BANKS x DEPTH words.
// s_ready drops after the last word until reload re-arms; optional TLAST framing check under CTRL_MEM_WRITE_TLAST_EN.
module ctrl_mem_write_banked #(
    parameter int DEPTH     = 20,
    parameter int NUM_BANKS = 1,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
`ifdef CTRL_MEM_WRITE_TLAST_EN
    input  logic                 s_last,
    output logic                 frame_err,
`endif
    input  logic                 reload,
    input  logic                 en_ext_ctrl,
    input  logic                 ext_load_addr,
    input  logic [ADDR_W-1:0]    ext_load_addr_val,
    input  logic [BANK_W-1:0]    ext_load_bank_val,
    input  logic                 ext_incr_addr,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [BANK_W-1:0]    mem_bank,
    output logic [NUM_BANKS-1:0] mem_wr_en,
    output logic                 fill_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [BANK_W-1:0] r_bank;
    logic              r_fill_done;

    logic              w_accept;
    logic              w_last_word;
    logic              w_full_trig;
    logic [ADDR_W-1:0] w_addr_inc;
    logic [BANK_W-1:0] w_bank_inc;
    logic              w_ld_addr_ok;
    logic              w_ld_bank_ok;

    assign w_accept    = s_valid & s_ready;
    assign w_last_word = (r_addr == LAST_ADDR) && (r_bank == LAST_BANK);

`ifdef CTRL_MEM_WRITE_TLAST_EN
    logic r_frame_err;

    // An early s_last ends the frame just like the final word does.
    assign w_full_trig = w_accept & (w_last_word | s_last);

    always_ff @(posedge clk) begin
        if (reset || reload) begin
            r_frame_err <= 1'b0;
        end else if (r_state == FILL && w_accept && (s_last != w_last_word)) begin
            r_frame_err <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`else
    assign w_full_trig = w_accept & w_last_word;
`endif

    // Shared wrap rule for auto increment and external increment.
    always_comb begin
        w_addr_inc = r_addr + ADDR_W'(1);
        w_bank_inc = r_bank;
        if (r_addr == LAST_ADDR) begin
            w_addr_inc = '0;
            w_bank_inc = (r_bank == LAST_BANK) ? '0 : r_bank + BANK_W'(1);
        end
    end

    assign w_ld_addr_ok = (32'(ext_load_addr_val) < 32'(DEPTH));
    assign w_ld_bank_ok = (32'(ext_load_bank_val) < 32'(NUM_BANKS));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (!reload && w_full_trig) w_state_nxt = FULL;
            FULL:    if (reload) w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_comb begin
        s_ready   = (r_state == FILL);
        mem_wr_en = w_accept ? (NUM_BANKS'(1) << r_bank) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr      <= '0;
            r_bank      <= '0;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            if (reload) begin
                r_addr <= '0;
                r_bank <= '0;
            end else if (r_state == FILL) begin
                if (w_full_trig) begin
                    r_addr      <= '0;
                    r_bank      <= '0;
                    r_fill_done <= 1'b1;
                end else if (en_ext_ctrl) begin
                    if (ext_load_addr) begin
                        if (w_ld_addr_ok) r_addr <= ext_load_addr_val;
                        if (w_ld_bank_ok) r_bank <= ext_load_bank_val;
                    end else if (ext_incr_addr) begin
                        r_addr <= w_addr_inc;
                        r_bank <= w_bank_inc;
                    end
                end else if (w_accept) begin
                    r_addr <= w_addr_inc;
                    r_bank <= w_bank_inc;
                end
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_bank  = r_bank;
    assign fill_done = r_fill_done;

endmodule
